rcs_status_axi_read: RTL and testbench
======================================

Name: rcs_status_axi_read

Overview:
- Downstream companion of the command-write stage. After the r/c1/c2/s command words for both accelerators are written to DDR, this block polls one status word per accelerator over an AXI4 master read channel.
- The status words live at 0x28040010 (accel1) and 0x28400020 (accel2).
- It reports completion, timeout or bus error back to the host-side controller.
- It is triggered by the command writer's done_write pulse.

Parameters:
- STAT_ADDR_1, 32'h28040010, DDR address of the accel1 status word.
- STAT_ADDR_2, 32'h28400020, DDR address of the accel2 status word.
- DONE_MASK, 32'h00000001, status bits that must all be 1 to count as done.
- POLL_GAP, 16, idle cycles between poll rounds (≥1).
- MAX_POLLS, 1024, poll rounds before timeout (≥1, ≤65535).

Ports:
- clk  in  1  clock.
- aresetn  in  1  async active-low reset.
- start_poll  in  1  1-cycle start pulse (driven from done_write).
- busy  out  1  high from the cycle after an accepted start until the result pulse.
- result_valid  out  1  1-cycle pulse; the result_* outputs are valid in that cycle.
- result_ok  out  1  both accelerators done.
- result_timeout  out  1  MAX_POLLS reached without done.
- result_err  out  1  nonzero RRESP seen.
- status1  out  32  last captured accel1 status word.
- status2  out  32  last captured accel2 status word.
- poll_count  out  16  poll rounds completed in the current or last operation.
- M_AXI_ARID  out  1.
- M_AXI_ARADDR  out  32.
- M_AXI_ARLEN  out  8.
- M_AXI_ARSIZE  out  3.
- M_AXI_ARBURST  out  2.
- M_AXI_ARLOCK  out  1.
- M_AXI_ARCACHE  out  4.
- M_AXI_ARPROT  out  3.
- M_AXI_ARQOS  out  4.
- M_AXI_ARUSER  out  1.
- M_AXI_ARVALID  out  1.
- M_AXI_ARREADY  in  1.
- M_AXI_RID  in  1.
- M_AXI_RDATA  in  32.
- M_AXI_RRESP  in  2.
- M_AXI_RLAST  in  1.
- M_AXI_RUSER  in  1.
- M_AXI_RVALID  in  1.
- M_AXI_RREADY  out  1.

Behaviour:
- Clock and reset: clk, with reset aresetn asynchronous, active-low.
- Reset values: all outputs 0, ARADDR 0, state IDLE, counters 0. Reset mid-operation aborts immediately with no result pulse; ARVALID and RREADY drop asynchronously.
- Constant AR fields:
  - ARID 0, ARLEN 0 (single beat), ARSIZE 3'b010, ARBURST 2'b01.
  - ARLOCK 0, ARCACHE 4'b0011, ARPROT 0, ARQOS 0, ARUSER 0.
- State machine: IDLE, AR1, R1, AR2, R2, CHECK, GAP, DONE.
- IDLE:
  - On start_poll, clear poll_count and the error flag, then go to AR1.
  - start_poll while not in IDLE is ignored.
- AR1 / AR2:
  - ARVALID=1 with ARADDR set to STAT_ADDR_1 or STAT_ADDR_2, registered.
  - ARADDR stays stable until ARVALID&ARREADY.
  - On handshake, ARVALID drops the next cycle and the FSM moves to R1 or R2.
  - Same-cycle ARREADY is allowed; an address is never re-issued before its data returns.
- R1 / R2:
  - RREADY=1 only in these states.
  - On RVALID&RREADY, capture RDATA into status1 or status2.
  - If RRESP!=0, set the sticky error flag.
  - RLAST is expected high. If RLAST is low, treat it as an error and keep RREADY high until the RLAST beat.
  - R1 advances to AR2; R2 advances to CHECK.
- CHECK (1 cycle), in priority order:
  1. Error flag set: go to DONE with err=1, ok=0, timeout=0.
  2. (status1&DONE_MASK)==DONE_MASK and the same holds for status2: go to DONE with ok=1.
  3. poll_count+1==MAX_POLLS: go to DONE with timeout=1.
  4. Otherwise go to GAP.
  - poll_count increments by 1 in CHECK on every path, saturating at 16'hFFFF.
- GAP:
  - A down-counter loaded with POLL_GAP counts to 0, then the FSM returns to AR1.
  - Exactly POLL_GAP cycles elapse between leaving CHECK and ARVALID reasserting.
- DONE:
  - result_valid=1 for one cycle, result_* held until the next start, then IDLE.
  - busy deasserts in the same cycle result_valid is high.
- Latency, zero-wait slave (ARREADY=1, RVALID the cycle after AR): start to result_valid on a first-poll success is 7 cycles.
- Status registers always hold the latest read, including on error or timeout.

Test Plan:
- Zero-wait slave returning 0x1 for both addresses, start pulse -> ARADDR sequence 0x28040010 then 0x28400020; result_valid after 7 cycles with ok=1; poll_count=1.
- Slave returns 0x0 for accel2 on rounds 1–3 and 0x1 from round 4 -> 4 round pairs with exactly 16 idle cycles between rounds; ok=1; poll_count=4; status2=0x1.
- Status words never done, MAX_POLLS=4 -> timeout=1, ok=0, poll_count=4; exactly 8 AR handshakes.
- RRESP=2'b10 on the accel1 read -> the accel2 read still issued; result err=1, ok=0; status1 holds the returned data.
- ARREADY delayed 5 cycles and RVALID delayed 3 cycles, with random backpressure -> ARVALID/ARADDR stable until handshake; RREADY high only in R states; result matches the zero-wait case.
- aresetn low in R2, then start_poll again after release -> no result pulse from the aborted operation; outputs zero; new poll completes normally. A start_poll pulse while busy produces no second operation.

Source files
------------

// File: rtl/rcs_status_axi_read_if.sv
`timescale 1ns/1ps
// AXI4 read-address / read-data channel bundle for the status poller.
// Master drives AR and RREADY; slave drives ARREADY and the R channel.
// Single-beat reads only; no write channels are carried.
interface rcs_status_axi_read_if;
    logic        M_AXI_ARID;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARLOCK;
    logic [3:0]  M_AXI_ARCACHE;
    logic [2:0]  M_AXI_ARPROT;
    logic [3:0]  M_AXI_ARQOS;
    logic        M_AXI_ARUSER;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic        M_AXI_RID;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RUSER;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    modport master (
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER,
               M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
               M_AXI_RUSER, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER,
               M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
               M_AXI_RUSER, M_AXI_RVALID
    );
endinterface

// File: rtl/rcs_status_axi_read.sv
`timescale 1ns/1ps
// Polls the accel1/accel2 status words over AXI4 read until both are done, timeout or bus error.
// Latency: 7 cycles start-to-result on a first-poll success with a zero-wait slave.
// Backpressure: holds ARVALID/ARADDR until ARREADY; RREADY only while a read is outstanding.
module rcs_status_axi_read #(
    parameter logic [31:0] STAT_ADDR_1 = 32'h28040010,
    parameter logic [31:0] STAT_ADDR_2 = 32'h28400020,
    parameter logic [31:0] DONE_MASK   = 32'h00000001,
    parameter int unsigned POLL_GAP    = 16,
    parameter int unsigned MAX_POLLS   = 1024
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        start_poll,
    output logic        busy,
    output logic        result_valid,
    output logic        result_ok,
    output logic        result_timeout,
    output logic        result_err,
    output logic [31:0] status1,
    output logic [31:0] status2,
    output logic [15:0] poll_count,
    rcs_status_axi_read_if.master m_axi
);
    typedef enum logic [2:0] {IDLE, AR1, R1, AR2, R2, CHECK, GAP, DONE} state_t;

    localparam logic [16:0] MAX_POLLS_W = 17'(MAX_POLLS);
    localparam logic [15:0] GAP_W       = 16'(POLL_GAP);

    state_t      state;
    logic        arvalid;
    logic        rready;
    logic [31:0] araddr;
    logic        err_flag;
    logic [15:0] gap_cnt;

    logic        ar_hs;
    logic        r_hs;
    logic        both_done;
    logic [16:0] next_count;
    logic        unused_ok;

    // Fixed single-beat, 32-bit, incrementing, modifiable-bufferable read attributes.
    assign m_axi.M_AXI_ARID    = 1'b0;
    assign m_axi.M_AXI_ARLEN   = 8'd0;
    assign m_axi.M_AXI_ARSIZE  = 3'b010;
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_ARLOCK  = 1'b0;
    assign m_axi.M_AXI_ARCACHE = 4'b0011;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARQOS   = 4'd0;
    assign m_axi.M_AXI_ARUSER  = 1'b0;
    assign m_axi.M_AXI_ARVALID = arvalid;
    assign m_axi.M_AXI_ARADDR  = araddr;
    assign m_axi.M_AXI_RREADY  = rready;

    assign unused_ok = &{1'b0, m_axi.M_AXI_RID, m_axi.M_AXI_RUSER};

    // Handshake strobes and the done/timeout decision inputs used in CHECK.
    always_comb begin
        ar_hs      = arvalid & m_axi.M_AXI_ARREADY;
        r_hs       = rready & m_axi.M_AXI_RVALID;
        both_done  = ((status1 & DONE_MASK) == DONE_MASK) &&
                     ((status2 & DONE_MASK) == DONE_MASK);
        next_count = {1'b0, poll_count} + 17'd1;
    end

    // Poll sequencer: AR/R pairs for each accelerator, evaluate, then wait POLL_GAP cycles.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= IDLE;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
            araddr         <= 32'd0;
            err_flag       <= 1'b0;
            gap_cnt        <= 16'd0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result_ok      <= 1'b0;
            result_timeout <= 1'b0;
            result_err     <= 1'b0;
            status1        <= 32'd0;
            status2        <= 32'd0;
            poll_count     <= 16'd0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_poll) begin
                        poll_count     <= 16'd0;
                        err_flag       <= 1'b0;
                        result_ok      <= 1'b0;
                        result_timeout <= 1'b0;
                        result_err     <= 1'b0;
                        busy           <= 1'b1;
                        araddr         <= STAT_ADDR_1;
                        arvalid        <= 1'b1;
                        state          <= AR1;
                    end
                end
                AR1: begin
                    if (ar_hs) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R1;
                    end
                end
                R1: begin
                    if (r_hs) begin
                        status1 <= m_axi.M_AXI_RDATA;
                        // A short burst (RLAST low) is a protocol error; drain until RLAST.
                        if (m_axi.M_AXI_RRESP != 2'b00 || !m_axi.M_AXI_RLAST)
                            err_flag <= 1'b1;
                        if (m_axi.M_AXI_RLAST) begin
                            rready  <= 1'b0;
                            araddr  <= STAT_ADDR_2;
                            arvalid <= 1'b1;
                            state   <= AR2;
                        end
                    end
                end
                AR2: begin
                    if (ar_hs) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R2;
                    end
                end
                R2: begin
                    if (r_hs) begin
                        status2 <= m_axi.M_AXI_RDATA;
                        if (m_axi.M_AXI_RRESP != 2'b00 || !m_axi.M_AXI_RLAST)
                            err_flag <= 1'b1;
                        if (m_axi.M_AXI_RLAST) begin
                            rready <= 1'b0;
                            state  <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (poll_count != 16'hFFFF)
                        poll_count <= poll_count + 16'd1;
                    if (err_flag) begin
                        result_err <= 1'b1;
                        state      <= DONE;
                    end else if (both_done) begin
                        result_ok <= 1'b1;
                        state     <= DONE;
                    end else if (next_count == MAX_POLLS_W) begin
                        result_timeout <= 1'b1;
                        state          <= DONE;
                    end else begin
                        gap_cnt <= GAP_W;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // Stays here for exactly POLL_GAP cycles before the next AR1.
                    if (gap_cnt <= 16'd1) begin
                        araddr  <= STAT_ADDR_1;
                        arvalid <= 1'b1;
                        state   <= AR1;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                DONE: begin
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rcs_status_axi_read.sv
`timescale 1ns/1ps
// Self-checking bench for rcs_status_axi_read: scripted AXI read slave with delays,
// scoreboard of expected results, AR address log and idle-gap log.
module tb_rcs_status_axi_read;
    localparam logic [31:0] STAT1 = 32'h28040010;
    localparam logic [31:0] STAT2 = 32'h28400020;

    logic        clk;
    logic        aresetn;
    logic        start_poll;
    logic        busy, result_valid, result_ok, result_timeout, result_err;
    logic [31:0] status1, status2;
    logic [15:0] poll_count;

    rcs_status_axi_read_if ifc();

    rcs_status_axi_read #(
        .STAT_ADDR_1 (STAT1),
        .STAT_ADDR_2 (STAT2),
        .DONE_MASK   (32'h00000001),
        .POLL_GAP    (16),
        .MAX_POLLS   (4)
    ) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .start_poll     (start_poll),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_ok      (result_ok),
        .result_timeout (result_timeout),
        .result_err     (result_err),
        .status1        (status1),
        .status2        (status2),
        .poll_count     (poll_count),
        .m_axi          (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave configuration
    int          ar_dly = 0, r_dly = 0;
    bit          bp = 0;
    int          acc1_from = 1, acc2_from = 1;   // round from which status reads done (0 = never)
    logic [31:0] acc1_val = 32'h1;
    logic [1:0]  acc1_resp = 2'b00;

    // Slave state and logs
    int          round = 0;
    int          ar_wait = -1, r_wait = 0;
    bit          r_pend = 0;
    logic [31:0] pend_addr, ar_first_addr;
    logic        arvalid_prev = 0, rready_prev = 0;
    logic [31:0] araddr_prev = 0;
    int          ar_stable_bad = 0, rready_bad = 0;
    logic [31:0] ar_log[$];
    int          gap_log[$];
    int          idle_run = 0;
    int          rv_count = 0;

    typedef logic [82:0] res_t;   // {ok, timeout, err, status1, status2, poll_count}
    res_t exp_q[$];

    function automatic logic [31:0] rd_data(input logic [31:0] a, input int rnd);
        if (a == STAT1) return (acc1_from != 0 && rnd >= acc1_from) ? acc1_val : 32'h0;
        return (acc2_from != 0 && rnd >= acc2_from) ? 32'h1 : 32'h0;
    endfunction

    // AXI read slave: decides at each falling edge what to present for the next rising edge.
    initial begin
        ifc.M_AXI_ARREADY = 0; ifc.M_AXI_RVALID = 0; ifc.M_AXI_RDATA = 0;
        ifc.M_AXI_RRESP = 0; ifc.M_AXI_RLAST = 0; ifc.M_AXI_RID = 0; ifc.M_AXI_RUSER = 0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                ifc.M_AXI_ARREADY = 0; ifc.M_AXI_RVALID = 0; ifc.M_AXI_RLAST = 0;
                ar_wait = -1; r_pend = 0;
                arvalid_prev = 0; rready_prev = 0;
                continue;
            end
            if (ifc.M_AXI_RVALID && rready_prev) begin
                ifc.M_AXI_RVALID = 0; ifc.M_AXI_RLAST = 0; ifc.M_AXI_RRESP = 0;
                r_pend = 0;
            end
            if (ifc.M_AXI_ARREADY && arvalid_prev) begin
                ifc.M_AXI_ARREADY = 0;
                ar_log.push_back(araddr_prev);
                if (araddr_prev == STAT1) round++;
                r_pend = 1;
                r_wait = r_dly + (bp ? int'($urandom_range(0, 2)) : 0);
                pend_addr = araddr_prev;
                ar_wait = -1;
            end
            if (ifc.M_AXI_RREADY && !r_pend) rready_bad++;
            if (r_pend && !ifc.M_AXI_RVALID) begin
                if (r_wait == 0) begin
                    ifc.M_AXI_RVALID = 1; ifc.M_AXI_RLAST = 1;
                    ifc.M_AXI_RDATA = rd_data(pend_addr, round);
                    ifc.M_AXI_RRESP = (pend_addr == STAT1) ? acc1_resp : 2'b00;
                end else r_wait--;
            end
            if (ar_wait >= 0 && !ifc.M_AXI_ARVALID) ar_stable_bad++;
            if (ifc.M_AXI_ARVALID && !ifc.M_AXI_ARREADY) begin
                if (ar_wait < 0) begin
                    ar_wait = ar_dly + (bp ? int'($urandom_range(0, 3)) : 0);
                    ar_first_addr = ifc.M_AXI_ARADDR;
                end else if (ifc.M_AXI_ARADDR !== ar_first_addr) ar_stable_bad++;
                if (ar_wait == 0) ifc.M_AXI_ARREADY = 1; else ar_wait--;
            end
            arvalid_prev = ifc.M_AXI_ARVALID;
            araddr_prev  = ifc.M_AXI_ARADDR;
            rready_prev  = ifc.M_AXI_RREADY;
        end
    end

    // Idle-run monitor (busy with neither AR nor R active) and result pulse counter.
    initial forever begin
        @(negedge clk);
        if (busy && !ifc.M_AXI_ARVALID && !ifc.M_AXI_RREADY) idle_run++;
        else if (ifc.M_AXI_ARVALID && idle_run > 0) begin
            gap_log.push_back(idle_run);
            idle_run = 0;
        end else if (!busy) idle_run = 0;
        if (result_valid) rv_count++;
    end

    int t_start;

    task automatic pulse_start;
        @(negedge clk);
        start_poll = 1; t_start = cyc;
        @(negedge clk);
        start_poll = 0;
    endtask

    task automatic wait_result(output bit got, output int lat);
        got = 0; lat = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (result_valid) got = 1;
            else @(negedge clk);
        end
        lat = cyc - t_start;
    endtask

    task automatic cfg(input int ad, input int rd, input bit b, input int a1, input int a2,
                       input logic [31:0] v1, input logic [1:0] rsp);
        ar_dly = ad; r_dly = rd; bp = b; acc1_from = a1; acc2_from = a2;
        acc1_val = v1; acc1_resp = rsp; round = 0;
        ar_log.delete(); gap_log.delete();
    endtask

    function automatic logic [118:0] out_vec();
        return {busy, result_valid, result_ok, result_timeout, result_err, status1, status2,
                poll_count, ifc.M_AXI_ARVALID, ifc.M_AXI_RREADY, ifc.M_AXI_ARADDR};
    endfunction

    task automatic test_reset;
        logic [118:0] ov;
        logic [26:0]  cf;
        aresetn = 0; start_poll = 0;
        repeat (3) @(negedge clk);
        ov = out_vec();
        n_cmp++;
        if (ov !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", ov); end
        cf = {ifc.M_AXI_ARID, ifc.M_AXI_ARLEN, ifc.M_AXI_ARSIZE, ifc.M_AXI_ARBURST,
              ifc.M_AXI_ARLOCK, ifc.M_AXI_ARCACHE, ifc.M_AXI_ARPROT, ifc.M_AXI_ARQOS, ifc.M_AXI_ARUSER};
        n_cmp++;
        if (cf !== {1'b0, 8'h00, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 1'b0}) begin
            n_bad++; $display("FAIL ar_constants: got %h", cf);
        end
        @(negedge clk); aresetn = 1;
        repeat (2) @(negedge clk);
    endtask

    // Runs one operation and compares result against the scoreboard head.
    task automatic run_and_check(input string nm, output int lat);
        bit   got;
        res_t e, a;
        pulse_start();
        wait_result(got, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL %s_no_result: result_valid never seen", nm);
        end else begin
            a = {result_ok, result_timeout, result_err, status1, status2, poll_count};
            if (a !== e) begin n_bad++; $display("FAIL %s_result: got %h want %h", nm, a, e); end
            n_cmp++;
            if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_at_result: got %b want 0", nm, busy); end
        end
    endtask

    task automatic check_ar_seq(input string nm, input int n);
        n_cmp++;
        if (ar_log.size() != n) begin
            n_bad++; $display("FAIL %s_ar_count: got %0d want %0d", nm, ar_log.size(), n);
        end
        for (int i = 0; i < ar_log.size() && i < n; i++) begin
            n_cmp++;
            if (ar_log[i] !== ((i % 2) ? STAT2 : STAT1)) begin
                n_bad++; $display("FAIL %s_araddr[%0d]: got %h want %h", nm, i, ar_log[i],
                                  (i % 2) ? STAT2 : STAT1);
            end
        end
    endtask

    task automatic test_first_poll;
        int lat;
        cfg(0, 0, 0, 1, 1, 32'h1, 2'b00);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h1, 32'h1, 16'd1});
        run_and_check("first_poll", lat);
        n_cmp++;
        if (lat != 7) begin n_bad++; $display("FAIL first_poll_latency: got %0d want 7", lat); end
        check_ar_seq("first_poll", 2);
    endtask

    task automatic test_multi_round;
        int lat;
        cfg(0, 0, 0, 1, 4, 32'h1, 2'b00);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h1, 32'h1, 16'd4});
        run_and_check("multi_round", lat);
        check_ar_seq("multi_round", 8);
        n_cmp++;
        if (gap_log.size() != 3) begin
            n_bad++; $display("FAIL multi_round_gap_count: got %0d want 3", gap_log.size());
        end
        // Idle run = the CHECK cycle plus 16 GAP cycles.
        foreach (gap_log[i]) begin
            n_cmp++;
            if (gap_log[i] != 17) begin
                n_bad++; $display("FAIL multi_round_gap[%0d]: got %0d want 17", i, gap_log[i]);
            end
        end
    endtask

    task automatic test_timeout;
        int lat;
        cfg(0, 0, 0, 0, 0, 32'h1, 2'b00);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd4});
        run_and_check("timeout", lat);
        check_ar_seq("timeout", 8);
    endtask

    task automatic test_rresp_err;
        int lat;
        cfg(0, 0, 0, 1, 1, 32'hA5A50001, 2'b10);
        exp_q.push_back({1'b0, 1'b0, 1'b1, 32'hA5A50001, 32'h1, 16'd1});
        run_and_check("rresp_err", lat);
        check_ar_seq("rresp_err", 2);
        acc1_resp = 2'b00;
    endtask

    task automatic test_backpressure;
        int lat;
        cfg(5, 3, 1, 1, 1, 32'h1, 2'b00);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h1, 32'h1, 16'd1});
        run_and_check("backpressure", lat);
        check_ar_seq("backpressure", 2);
        n_cmp++;
        if (ar_stable_bad != 0) begin n_bad++; $display("FAIL ar_stability: got %0d violations want 0", ar_stable_bad); end
        n_cmp++;
        if (rready_bad != 0) begin n_bad++; $display("FAIL rready_outside_read: got %0d want 0", rready_bad); end
    endtask

    task automatic test_reset_abort;
        int  lat, rv0;
        bit  seen;
        logic [118:0] ov;
        cfg(0, 4, 0, 1, 1, 32'h1, 2'b00);
        pulse_start();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (ar_log.size() >= 2) seen = 1; else @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL abort_reach_r2: second AR never issued"); end
        aresetn = 0;
        #1;
        ov = out_vec();
        n_cmp++;
        if (ov !== '0) begin n_bad++; $display("FAIL abort_outputs: got %h want 0", ov); end
        rv0 = rv_count;
        repeat (3) @(negedge clk);
        aresetn = 1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rv_count != rv0) begin n_bad++; $display("FAIL abort_no_pulse: got %0d pulses want 0", rv_count - rv0); end
        cfg(0, 0, 0, 1, 1, 32'h1, 2'b00);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h1, 32'h1, 16'd1});
        fork
            run_and_check("after_abort", lat);
            begin
                repeat (3) @(negedge clk);
                start_poll = 1;
                @(negedge clk);
                start_poll = 0;
            end
        join
        repeat (40) @(negedge clk);
        n_cmp++;
        if (rv_count != rv0 + 1) begin n_bad++; $display("FAIL start_while_busy_pulses: got %0d want 1", rv_count - rv0); end
        check_ar_seq("start_while_busy", 2);
    endtask

    initial begin
        aresetn = 0; start_poll = 0;
        test_reset();
        test_first_poll();
        test_multi_round();
        test_timeout();
        test_rresp_err();
        test_backpressure();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
